// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the pipeline control blocks
package cpu_pkg;
  typedef enum logic {IDLE, BUSY} mdu_st_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MDU_LAT_DEF = 4;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID/EX hazard inputs and pipeline-register controls
interface hazard_ctrl_if #(parameter int CNTW = 16);
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo, id_redirect, ex_memread;
  logic stall_pc, stall_if_id, flush_if_id, flush_id_ex, mdu_busy;
  logic [CNTW-1:0] stall_count;
  modport master (
    output id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo, id_redirect, ex_memread,
    input stall_pc, stall_if_id, flush_if_id, flush_id_ex, mdu_busy, stall_count
  );
  modport slave (
    input id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, id_mdu_start, id_reads_hilo, id_redirect, ex_memread,
    output stall_pc, stall_if_id, flush_if_id, flush_id_ex, mdu_busy, stall_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: counts inc cycles, holds at all-ones, async clear on rst_n
module sat_counter #(parameter int N = 16) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [N-1:0] q
);
  // increment unless already saturated
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and MDU hazard control for the 5-stage pipeline
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNTW    = 16
) (
  input logic         clk,
  input logic         rst_n,
  hazard_ctrl_if.slave h
);
  mdu_st_t    st;
  logic [3:0] cnt;
  logic       lu_haz, mdu_haz, stall;
  assign lu_haz  = h.ex_memread && (h.ex_rt != REG_ZERO) &&
                   ((h.id_uses_rs && h.id_rs == h.ex_rt) || (h.id_uses_rt && h.id_rt == h.ex_rt));
  assign mdu_haz = (st == BUSY) && (h.id_mdu_start || h.id_reads_hilo);
  assign stall   = lu_haz || mdu_haz;
  assign h.stall_pc    = stall;
  assign h.stall_if_id = stall;
  assign h.flush_id_ex = stall;
  assign h.flush_if_id = h.id_redirect && !stall;
  assign h.mdu_busy    = (st == BUSY);
  // MDU occupancy: load on unstalled issue, leave BUSY when the count runs out
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= '0;
    end else if (st == IDLE) begin
      if (h.id_mdu_start && !stall) begin
        st  <= BUSY;
        cnt <= 4'(MDU_LAT - 1);
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) st <= IDLE;
    end
  sat_counter #(.N(CNTW)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall),
    .q    (h.stall_count)
  );
endmodule
